ps2_mouse_packet_decoder: RTL and testbench

//  Parametrised successor to the 3-byte mouse decoder. Assembles PS/2 mouse bytes into
//  3-byte standard or 4-byte wheel packets, with bit-3 resync and inter-byte timeout recovery.

---
 rtl/ps2_mouse_packet_decoder.sv | 160 ++++++++++++++++
 tb/tb_ps2_mouse_packet_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_packet_decoder.sv
// PS/2 mouse packet decoder: assembles 3- or 4-byte packets from a byte strobe, decodes
// deltas/buttons/wheel and keeps a clamped cursor position, with header resync and idle timeout.
module ps2_mouse_packet_decoder #(
    parameter int PKT_BYTES   = 3,
    parameter int XW          = 10,
    parameter int YW          = 9,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int DIV_SHIFT   = 0,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mouseReady,
    input  logic [7:0]    mouseData,
    output logic          decodeReady,
    output logic [8:0]    mousedx,
    output logic [8:0]    mousedy,
    output logic [XW-1:0] mouseX,
    output logic [YW-1:0] mouseY,
    output logic [2:0]    mousebtn,
    output logic [3:0]    mousewheel,
    output logic          overflow,
    output logic          sync_err,
    output logic [1:0]    dbg_state
);
    localparam int TW     = $clog2(TIMEOUT_CYC + 1);
    localparam int X_HALF = X_MAX / 2;
    localparam int Y_HALF = Y_MAX / 2;
    localparam int T_LAST = TIMEOUT_CYC - 1;
    localparam logic signed [XW+1:0] X_MAX_S = X_MAX[XW+1:0];
    localparam logic signed [YW+1:0] Y_MAX_S = Y_MAX[YW+1:0];

    typedef enum logic [1:0] {S_B0, S_B1, S_B2, S_B3} state_t;

    state_t        r_state;
    logic          r_ready_d;
    logic [TW-1:0] r_cnt;
    logic [7:0]    r_hdr, r_b1, r_b2, r_b3;
    logic          r_pend;

    logic                 w_accept;
    logic                 w_timeout;
    logic signed [8:0]    w_dx_raw, w_dy_raw, w_dx_sh, w_dy_sh;
    logic signed [XW+1:0] w_nx;
    logic signed [YW+1:0] w_ny;
    logic [XW-1:0]        w_cx;
    logic [YW-1:0]        w_cy;
    logic [3:0]           w_wheel;

    assign dbg_state = r_state;
    assign w_accept  = mouseReady & ~r_ready_d;
    assign w_timeout = (r_state != S_B0) && (r_cnt == T_LAST[TW-1:0]);

    // Raw 9-bit deltas are reported as-is; overflow only suppresses accumulation.
    assign w_dx_raw = {r_hdr[4], r_b1};
    assign w_dy_raw = {r_hdr[5], r_b2};
    assign w_dx_sh  = r_hdr[6] ? 9'sd0 : (w_dx_raw >>> DIV_SHIFT);
    assign w_dy_sh  = r_hdr[7] ? 9'sd0 : (w_dy_raw >>> DIV_SHIFT);

    assign w_nx = {2'b00, mouseX} + {{(XW-7){w_dx_sh[8]}}, w_dx_sh};
    assign w_ny = {2'b00, mouseY} - {{(YW-7){w_dy_sh[8]}}, w_dy_sh};

    always_comb begin
        w_cx = w_nx[XW-1:0];
        if (w_nx < 0)
            w_cx = '0;
        else if (w_nx > X_MAX_S)
            w_cx = X_MAX_S[XW-1:0];
    end

    always_comb begin
        w_cy = w_ny[YW-1:0];
        if (w_ny < 0)
            w_cy = '0;
        else if (w_ny > Y_MAX_S)
            w_cy = Y_MAX_S[YW-1:0];
    end

    assign w_wheel = (PKT_BYTES == 4) ? r_b3[3:0] : 4'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_B0;
            r_ready_d   <= 1'b0;
            r_cnt       <= '0;
            r_hdr       <= '0;
            r_b1        <= '0;
            r_b2        <= '0;
            r_b3        <= '0;
            r_pend      <= 1'b0;
            decodeReady <= 1'b0;
            mousedx     <= '0;
            mousedy     <= '0;
            mouseX      <= X_HALF[XW-1:0];
            mouseY      <= Y_HALF[YW-1:0];
            mousebtn    <= '0;
            mousewheel  <= '0;
            overflow    <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            r_ready_d   <= mouseReady;
            decodeReady <= 1'b0;
            sync_err    <= 1'b0;
            r_pend      <= 1'b0;

            // Commit one cycle after the final byte; header/bytes are stable by then.
            if (r_pend) begin
                mousedx     <= w_dx_raw;
                mousedy     <= w_dy_raw;
                mouseX      <= w_cx;
                mouseY      <= w_cy;
                mousebtn    <= r_hdr[2:0];
                mousewheel  <= w_wheel;
                overflow    <= r_hdr[7] | r_hdr[6];
                decodeReady <= 1'b1;
            end

            if (w_accept) begin
                r_cnt <= '0;
                case (r_state)
                    S_B0: begin
                        if (mouseData[3]) begin
                            r_hdr   <= mouseData;
                            r_state <= S_B1;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                    S_B1: begin
                        r_b1    <= mouseData;
                        r_state <= S_B2;
                    end
                    S_B2: begin
                        r_b2 <= mouseData;
                        if (PKT_BYTES == 4) begin
                            r_state <= S_B3;
                        end else begin
                            r_state <= S_B0;
                            r_pend  <= 1'b1;
                        end
                    end
                    default: begin
                        r_b3    <= mouseData;
                        r_state <= S_B0;
                        r_pend  <= 1'b1;
                    end
                endcase
            end else if (r_state == S_B0) begin
                r_cnt <= '0;
            end else if (w_timeout) begin
                r_state  <= S_B0;
                r_cnt    <= '0;
                sync_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Directed bench for ps2_mouse_packet_decoder: a 3-byte and a 4-byte instance, each with a
// commit scoreboard fed by a simple integer cursor model.
module tb_ps2_mouse_packet_decoder;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       rdy_a = 1'b0, rdy_b = 1'b0;
    logic [7:0] data_a = 8'h00, data_b = 8'h00;

    logic       dr_a, dr_b, ovf_a, ovf_b, se_a, se_b;
    logic [8:0] dx_a, dy_a, dx_b, dy_b;
    logic [9:0] x_a, x_b;
    logic [8:0] y_a, y_b;
    logic [2:0] btn_a, btn_b;
    logic [3:0] wh_a, wh_b;
    logic [1:0] st_a, st_b;

    ps2_mouse_packet_decoder #(.PKT_BYTES(3), .TIMEOUT_CYC(TO)) dut_a (
        .clk(clk), .rst(rst), .mouseReady(rdy_a), .mouseData(data_a),
        .decodeReady(dr_a), .mousedx(dx_a), .mousedy(dy_a), .mouseX(x_a), .mouseY(y_a),
        .mousebtn(btn_a), .mousewheel(wh_a), .overflow(ovf_a), .sync_err(se_a),
        .dbg_state(st_a));

    ps2_mouse_packet_decoder #(.PKT_BYTES(4), .TIMEOUT_CYC(TO)) dut_b (
        .clk(clk), .rst(rst), .mouseReady(rdy_b), .mouseData(data_b),
        .decodeReady(dr_b), .mousedx(dx_b), .mousedy(dy_b), .mouseX(x_b), .mouseY(y_b),
        .mousebtn(btn_b), .mousewheel(wh_b), .overflow(ovf_b), .sync_err(se_b),
        .dbg_state(st_b));

    int n_tests = 0;
    int n_fail  = 0;
    int commits_a = 0, commits_b = 0, syncs_a = 0, syncs_b = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;
    int mx_a = 319, my_a = 239, mx_b = 319, my_b = 239;
    logic [44:0] exp_qa[$];
    logic [44:0] exp_qb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // {dx, dy, x, y, btn, wheel, overflow}
    function automatic logic [44:0] model(input logic [7:0] h, b1, b2, input logic [3:0] wh,
                                          input int x0, y0, output int x1, output int y1);
        int dx, dy;
        logic [31:0] dxv, dyv, xv, yv;
        dx = h[4] ? int'(b1) - 256 : int'(b1);
        dy = h[5] ? int'(b2) - 256 : int'(b2);
        x1 = h[6] ? x0 : x0 + dx;
        y1 = h[7] ? y0 : y0 - dy;
        if (x1 < 0) x1 = 0;
        if (x1 > 639) x1 = 639;
        if (y1 < 0) y1 = 0;
        if (y1 > 479) y1 = 479;
        dxv = dx; dyv = dy; xv = x1; yv = y1;
        return {dxv[8:0], dyv[8:0], xv[9:0], yv[8:0], h[2:0], wh, h[7] | h[6]};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (dr_a) begin
                commits_a++;
                chk("dr_a_single", {63'd0, prev_a}, 64'd0);
                chk("sb_a_nonempty", {63'd0, exp_qa.size() != 0}, 64'd1);
                if (exp_qa.size() != 0)
                    chk("sb_a_pkt", {19'd0, dx_a, dy_a, x_a, y_a, btn_a, wh_a, ovf_a},
                        {19'd0, exp_qa.pop_front()});
            end
            if (dr_b) begin
                commits_b++;
                chk("dr_b_single", {63'd0, prev_b}, 64'd0);
                chk("sb_b_nonempty", {63'd0, exp_qb.size() != 0}, 64'd1);
                if (exp_qb.size() != 0)
                    chk("sb_b_pkt", {19'd0, dx_b, dy_b, x_b, y_b, btn_b, wh_b, ovf_b},
                        {19'd0, exp_qb.pop_front()});
            end
            if (se_a) syncs_a++;
            if (se_b) syncs_b++;
        end
        prev_a = dr_a;
        prev_b = dr_b;
    end

    task automatic send_a(input logic [7:0] b, input int hold);
        data_a = b; rdy_a = 1'b1;
        repeat (hold) @(negedge clk);
        rdy_a = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] b, input int hold);
        data_b = b; rdy_b = 1'b1;
        repeat (hold) @(negedge clk);
        rdy_b = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_commits(input string tag, input int which, input int target);
        for (int i = 0; i < 20; i++) begin
            if ((which == 0 ? commits_a : commits_b) >= target) break;
            @(negedge clk);
        end
        chk(tag, which == 0 ? commits_a : commits_b, target);
    endtask

    task automatic pkt_a(input logic [7:0] h, b1, b2);
        int c0, nx, ny;
        c0 = commits_a;
        exp_qa.push_back(model(h, b1, b2, 4'd0, mx_a, my_a, nx, ny));
        mx_a = nx; my_a = ny;
        send_a(h, 1); send_a(b1, 1); send_a(b2, 1);
        wait_commits("commit_a", 0, c0 + 1);
    endtask

    task automatic pkt_b(input logic [7:0] h, b1, b2, b3, input int hold);
        int c0, nx, ny;
        c0 = commits_b;
        exp_qb.push_back(model(h, b1, b2, b3[3:0], mx_b, my_b, nx, ny));
        mx_b = nx; my_b = ny;
        send_b(h, hold); send_b(b1, hold); send_b(b2, hold);
        chk("b_no_early_commit", commits_b, c0);
        send_b(b3, hold);
        wait_commits("commit_b", 1, c0 + 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mx_a = 319; my_a = 239; mx_b = 319; my_b = 239;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, c0;
        do_reset();

        chk("rst_x", x_a, 319);
        chk("rst_y", y_a, 239);
        chk("rst_dr", dr_a, 0);
        chk("rst_deltas", {dx_a, dy_a, btn_a, wh_a, ovf_a, se_a}, 0);
        chk("rst_state", st_a, 0);
        chk("rst_b_xy", {x_b, y_b}, {10'd319, 9'd239});

        pkt_a(8'h08, 8'h05, 8'h0A);
        chk("p1_dx", dx_a, 9'd5);
        chk("p1_dy", dy_a, 9'd10);
        chk("p1_xy", {x_a, y_a}, {10'd324, 9'd229});

        s0 = syncs_a; c0 = commits_a;
        send_a(8'h00, 1);
        chk("drop_sync", syncs_a - s0, 1);
        chk("drop_nocommit", commits_a, c0);
        pkt_a(8'h09, 8'h00, 8'h00);
        chk("btn_left", btn_a, 3'b001);
        chk("btn_xy_hold", {x_a, y_a}, {10'd324, 9'd229});

        // Partial packet then reset: nothing should commit.
        c0 = commits_a;
        send_a(8'h08, 1); send_a(8'h01, 1);
        do_reset();
        repeat (5) @(negedge clk);
        chk("rst_mid_pkt", commits_a, c0);
        chk("rst_mid_x", x_a, 319);

        pkt_a(8'h18, 8'h80, 8'h00);
        chk("clamp_x1", x_a, 191);
        pkt_a(8'h18, 8'h80, 8'h00);
        chk("clamp_x2", x_a, 63);
        pkt_a(8'h18, 8'h80, 8'h00);
        chk("clamp_x3", x_a, 0);

        pkt_a(8'h48, 8'h7F, 8'h00);
        chk("ovf_flag", ovf_a, 1);
        chk("ovf_dx_raw", dx_a, 9'h07F);
        chk("ovf_x_hold", x_a, 0);

        s0 = syncs_a; c0 = commits_a;
        send_a(8'h08, 1); send_a(8'h05, 1);
        repeat (120) @(negedge clk);
        chk("timeout_sync", syncs_a - s0, 1);
        chk("timeout_nocommit", commits_a, c0);
        pkt_a(8'h08, 8'h01, 8'h01);
        chk("timeout_one_commit", commits_a - c0, 1);
        chk("after_to_dxdy", {dx_a, dy_a}, {9'd1, 9'd1});

        pkt_b(8'h08, 8'h00, 8'h00, 8'h0F, 1);
        chk("wheel_neg1", wh_b, 4'hF);
        pkt_b(8'h0A, 8'h03, 8'h00, 8'h02, 5);
        chk("wheel_2_hold5", wh_b, 4'h2);
        pkt_b(8'h08, 8'h00, 8'h00, 8'h0F, 5);
        chk("wheel_hold5", wh_b, 4'hF);
        chk("b_xy", {x_b, y_b}, {10'd322, 9'd239});
        chk("b_commits", commits_b, 3);
        chk("sb_drained", exp_qa.size() + exp_qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
